// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared MDU operation codes, FSM state encoding and default latencies.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int C_MULT_CYCLES_DEF = 5;
  localparam int C_DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module  : mdu_arith
// Brief   : Combinational mult/multu/div/divu datapath producing {hi, lo}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic signed [63:0] sa64_w, sb64_w, sprod_w;
  logic        [63:0] uprod_w;
  logic        [31:0] bsafe_w, squot_w, srem_w, uquot_w, urem_w;
  logic               ovf_w;

  assign div_zero_o = (b_i == 32'd0);
  // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded anyway.
  assign bsafe_w    = div_zero_o ? 32'd1 : b_i;
  assign ovf_w      = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  assign sa64_w  = {{32{a_i[31]}}, a_i};
  assign sb64_w  = {{32{b_i[31]}}, b_i};
  assign sprod_w = sa64_w * sb64_w;
  assign uprod_w = {32'd0, a_i} * {32'd0, b_i};

  assign squot_w = ovf_w ? 32'h8000_0000 : 32'($signed(a_i) / $signed(bsafe_w));
  assign srem_w  = ovf_w ? 32'd0         : 32'($signed(a_i) % $signed(bsafe_w));
  assign uquot_w = a_i / bsafe_w;
  assign urem_w  = a_i % bsafe_w;

  always_comb begin
    res_o = 64'd0;
    case (op_i)
      OP_MULT:  res_o = sprod_w;
      OP_MULTU: res_o = uprod_w;
      OP_DIV:   res_o = {srem_w, squot_w};
      OP_DIVU:  res_o = {urem_w, uquot_w};
      default:  res_o = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_controller.sv
// ============================================================================
// Module  : mdu_controller
// Brief   : Multi-cycle MDU scheduler owning HI/LO; optional Flush via MDU_FLUSH_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_controller
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_FLUSH_EN
  input  logic        Flush,
`endif
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int C_MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

  mdu_state_e         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]        res_q, res_d;
  logic               res_wr_q, res_wr_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic [63:0]        arith_res_w;
  logic               div_zero_w;
  logic               flush_w;
  logic               idle_w;

`ifdef MDU_FLUSH_EN
  assign flush_w = Flush;
`else
  assign flush_w = 1'b0;
`endif

  mdu_arith u_arith (
    .a_i        (A),
    .b_i        (B),
    .op_i       (MDUCtrl),
    .res_o      (arith_res_w),
    .div_zero_o (div_zero_w)
  );

  assign idle_w = (state_q == S_IDLE);
  assign Start  = MDUEN & is_arith_op(MDUCtrl) & idle_w & ~flush_w;
  assign Busy   = (state_q == S_RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_wr_d = res_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          res_d    = arith_res_w;
          res_wr_d = ~(is_div_op(MDUCtrl) & div_zero_w);
          cnt_d    = is_div_op(MDUCtrl) ? C_CNT_W'(DIV_CYCLES - 1) : C_CNT_W'(MULT_CYCLES - 1);
          state_d  = S_RUN;
        end else if (MDUEN && !flush_w) begin
          if (MDUCtrl == OP_MTHI) hi_d = A;
          if (MDUCtrl == OP_MTLO) lo_d = A;
        end
      end
      S_RUN: begin
        // Abort wins over completion so a cancelled op never touches HI/LO.
        if (flush_w) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (res_wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_q    <= 64'd0;
      res_wr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_wr_q <= res_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_controller.sv
// ============================================================================
// Module  : tb_mdu_controller
// Brief   : Self-checking bench for mdu_controller against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_controller;

  localparam int C_MULT = 5;
  localparam int C_DIV  = 10;

  logic        clk;
  logic        reset;
  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic [31:0] A, B;
  logic        Flush;
  logic        Start, Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  // Model state: architectural HI/LO, remaining busy cycles and the pending result.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwr;
  int          m_left;

  mdu_controller #(.MULT_CYCLES(C_MULT), .DIV_CYCLES(C_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .MDUEN   (MDUEN),
    .MDUCtrl (MDUCtrl),
    .A       (A),
    .B       (B),
`ifdef MDU_FLUSH_EN
    .Flush   (Flush),
`endif
    .Start   (Start),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic wr);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    hi = 32'd0; lo = 32'd0; wr = 1'b1;
    case (op)
      3'd1: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
      3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd3: if (b == 0) wr = 1'b0; else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      3'd4: if (b == 0) wr = 1'b0; else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
      default: wr = 1'b0;
    endcase
  endtask

  // One clock: drive inputs, check Start, advance the model, then check registered outputs.
  task automatic cyc(input logic rn, input logic en, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic fle, exp_start;
    reset = rn; MDUEN = en; MDUCtrl = op; A = a; B = b; Flush = fl;
`ifdef MDU_FLUSH_EN
    fle = fl;
`else
    fle = 1'b0;
`endif
    #1;
    exp_start = en && (op >= 3'd1) && (op <= 3'd4) && (m_left == 0) && !fle;
    chk("start", 64'(Start), 64'(exp_start));
    if (!rn) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_phi = 0; m_plo = 0; m_pwr = 0;
    end else if (m_left > 0) begin
      if (fle) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
      end
    end else if (en && !fle) begin
      if (exp_start) begin
        ref_op(op, a, b, m_phi, m_plo, m_pwr);
        m_left = (op >= 3'd3) ? C_DIV : C_MULT;
      end else if (op == 3'd5) m_hi = a;
      else if (op == 3'd6) m_lo = a;
    end
    @(posedge clk); #1;
    chk("busy", 64'(Busy), 64'(m_left > 0));
    chk("hi", 64'(HI), 64'(m_hi));
    chk("lo", 64'(LO), 64'(m_lo));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic op1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cyc(1'b1, 1'b1, op, a, b, 1'b0);
  endtask

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

    op1(3'd1, 32'hFFFF_FFFE, 32'd3);
    idle(C_MULT);
    chk("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFA);

    op1(3'd4, 32'd100, 32'd7);
    for (int i = 0; i < C_DIV; i++) begin
      chk("stall", 64'(Start | Busy), 64'd1);
      idle(1);
    end
    chk("divu_lo", 64'(LO), 64'd14);
    chk("divu_hi", 64'(HI), 64'd2);

    op1(3'd3, 32'hFFFF_FFF9, 32'd2);
    idle(C_DIV);
    chk("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);

    op1(3'd5, 32'h1234, 32'd0);
    op1(3'd3, 32'd55, 32'd0);
    idle(C_DIV);
    chk("dz_hi", 64'(HI), 64'h1234);

    op1(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(C_DIV);
    chk("ovf_lo", 64'(LO), 64'h0000_0000_8000_0000);
    chk("ovf_hi", 64'(HI), 64'd0);

    op1(3'd1, 32'd9, 32'd9);
    op1(3'd3, 32'd40, 32'd4);
    op1(3'd5, 32'hDEAD, 32'd0);
    op1(3'd7, 32'hBEEF, 32'd1);
    idle(C_MULT);
    chk("busy_ign_lo", 64'(LO), 64'd81);
    op1(3'd7, 32'hBEEF, 32'd1);
    op1(3'd0, 32'hBEEF, 32'd1);

    op1(3'd1, 32'd3, 32'd4);
    idle(2);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    op1(3'd6, 32'h55, 32'd0);
    chk("mtlo", 64'(LO), 64'h55);

`ifdef MDU_FLUSH_EN
    op1(3'd6, 32'h77, 32'd0);
    op1(3'd2, 32'd5, 32'd5);
    idle(1);
    cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("flush_busy", 64'(Busy), 64'd0);
    chk("flush_lo", 64'(LO), 64'h77);
    cyc(1'b1, 1'b1, 3'd5, 32'h99, 32'd0, 1'b1);
`endif

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7),
          3'($urandom_range(0, 7)), a, b, ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
